// File: rtl/sobig_arith_pkg.sv
// Shared arithmetic datapath definitions: default widths, sequencer state
// encoding and counter sizing, common to the multiplier and divider.
package sobig_arith_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int DOTW_DEF  = 7;
  localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sobig_mul_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// upper half of the accumulator, then shift {carry,acc} and the multiplier.
module sobig_mul_step #(
  parameter int WIDTH = 64
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mplr_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   mplr_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (mplr_i[0] ? {1'b0, mcand_i} : '0);
    // the carry out of the add becomes the new accumulator MSB
    acc_o  = {sum, acc_i[WIDTH-1:1]};
    mplr_o = {1'b0, mplr_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/sobig_multiplication.sv
// Sequential sign-magnitude fixed-point multiplier, one multiplier bit per clock.
// Optional EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module sobig_multiplication
  import sobig_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DOTW  = DOTW_DEF
) (
  input  logic               systclk,
  input  logic               systrst,
  input  logic               init,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [DOTW-1:0]    dotplace1,
  input  logic [DOTW-1:0]    dotplace2,
  input  logic               sign1,
  input  logic               sign2,
  output logic [2*WIDTH-1:0] result,
  output logic [DOTW:0]      dotplaceresult,
  output logic               signresult,
  output logic               busy,
  output logic               calcover
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);
`ifdef EARLY_EXIT_EN
  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);
`endif

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [DOTW-1:0]    dp1_q, dp1_d, dp2_q, dp2_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [DOTW:0]      dpr_q, dpr_d;
  logic               sr_q, sr_d;
  logic               busy_q, busy_d;
  logic               calcover_q, calcover_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   step_mplr;

  sobig_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mplr_i  (mplr_q),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .mplr_o  (step_mplr)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplr_d     = mplr_q;
    dp1_d      = dp1_q;
    dp2_d      = dp2_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    dpr_d      = dpr_q;
    sr_d       = sr_q;
    busy_d     = busy_q;
    calcover_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          mcand_d = num1;
          mplr_d  = num2;
          dp1_d   = dotplace1;
          dp2_d   = dotplace2;
          s1_d    = sign1;
          s2_d    = sign2;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = step_acc;
        mplr_d = step_mplr;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
`ifdef EARLY_EXIT_EN
        else if (step_mplr == '0) begin
          // remaining shifts are pure right shifts of the accumulator
          acc_d   = step_acc >> (WIDTH_C - cnt_d);
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        result_d   = acc_q;
        dpr_d      = {1'b0, dp1_q} + {1'b0, dp2_q};
        sr_d       = s1_q ^ s2_q;
        calcover_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge systclk or posedge systrst) begin
    if (systrst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplr_q     <= '0;
      dp1_q      <= '0;
      dp2_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      dpr_q      <= '0;
      sr_q       <= 1'b0;
      busy_q     <= 1'b0;
      calcover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplr_q     <= mplr_d;
      dp1_q      <= dp1_d;
      dp2_q      <= dp2_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      dpr_q      <= dpr_d;
      sr_q       <= sr_d;
      busy_q     <= busy_d;
      calcover_q <= calcover_d;
    end
  end

  assign result         = result_q;
  assign dotplaceresult = dpr_q;
  assign signresult     = sr_q;
  assign busy           = busy_q;
  assign calcover       = calcover_q;

endmodule

// File: tb/tb_sobig_multiplication.sv
// Bench for sobig_multiplication: directed and random products checked
// against 128-bit arithmetic; honours EARLY_EXIT_EN for latency.
module tb_sobig_multiplication;

  logic         systclk = 1'b0;
  logic         systrst;
  logic         init;
  logic [63:0]  num1, num2;
  logic [6:0]   dotplace1, dotplace2;
  logic         sign1, sign2;
  logic [127:0] result;
  logic [7:0]   dotplaceresult;
  logic         signresult, busy, calcover;

  int vec = 0;
  int errs = 0;
  logic [127:0] last_res = '0;

  sobig_multiplication dut (
    .systclk(systclk), .systrst(systrst), .init(init),
    .num1(num1), .num2(num2), .dotplace1(dotplace1), .dotplace2(dotplace2),
    .sign1(sign1), .sign2(sign2), .result(result), .dotplaceresult(dotplaceresult),
    .signresult(signresult), .busy(busy), .calcover(calcover)
  );

  always #5 systclk = ~systclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // edges from the init sample edge until calcover is visible
  function automatic int exp_lat(input logic [63:0] b);
`ifdef EARLY_EXIT_EN
    int r = 1;
    for (int i = 0; i < 64; i++) if (b[i]) r = i + 1;
    return r + 1;
`else
    return 65;
`endif
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_result"}, result, 128'd0);
    chk({tag, "_dp"}, {120'd0, dotplaceresult}, 128'd0);
    chk({tag, "_sign"}, {127'd0, signresult}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_calcover"}, {127'd0, calcover}, 128'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [6:0] d1, input logic [6:0] d2,
                        input logic s1, input logic s2,
                        input int poke_cyc, input int rst_cyc);
    logic [127:0] p;
    int n, lat;
    bit seen, rst_hit, late;
    p   = {64'd0, a} * {64'd0, b};
    lat = exp_lat(b);
    num1 = a; num2 = b; dotplace1 = d1; dotplace2 = d2; sign1 = s1; sign2 = s2;
    init = 1'b1;
    @(posedge systclk); #1;
    init = 1'b0;
    n = 0; seen = 0; rst_hit = 0;
    while (!seen && !rst_hit && n < 300) begin
      @(posedge systclk); #1;
      n++;
      if (n == 1) begin
        chk("busy_in_run", {127'd0, busy}, 128'd1);
        chk("result_held", result, last_res);
      end
      if (calcover) seen = 1;
      init = (n == poke_cyc);
      if (n == poke_cyc) num1 = 64'd1;
      if (n == rst_cyc) begin
        systrst = 1'b1;
        #1;
        check_zero_outputs("midrun_reset");
        @(posedge systclk); #1;
        systrst = 1'b0;
        rst_hit = 1;
      end
    end
    init = 1'b0;
    if (rst_hit) begin
      late = 0;
      for (int i = 0; i < 75; i++) begin
        @(posedge systclk); #1;
        if (calcover || busy) late = 1;
      end
      chk("no_calcover_after_reset", {127'd0, late}, 128'd0);
      chk("result_after_reset", result, 128'd0);
      last_res = '0;
    end else begin
      chk("calcover_seen", {127'd0, seen}, 128'd1);
      chk("latency", 128'(n), 128'(lat));
      chk("result", result, p);
      chk("dotplace", {120'd0, dotplaceresult}, 128'({1'b0, d1} + {1'b0, d2}));
      chk("sign", {127'd0, signresult}, {127'd0, s1 ^ s2});
      chk("busy_after", {127'd0, busy}, 128'd0);
      last_res = p;
      @(posedge systclk); #1;
      chk("calcover_one_cycle", {127'd0, calcover}, 128'd0);
      chk("result_stable", result, p);
    end
  endtask

  initial begin
    logic [63:0]  ra, rb;
    logic [63:0]  qa[3], qb[3];
    logic [6:0]   qd1[3], qd2[3];
    logic         qs1[3], qs2[3];
    int n, i, guard, poke;
    systrst = 1'b1; init = 1'b0;
    num1 = '0; num2 = '0; dotplace1 = '0; dotplace2 = '0; sign1 = 1'b0; sign2 = 1'b0;
    repeat (2) @(posedge systclk);
    #1;
    check_zero_outputs("reset");
    systrst = 1'b0;
    @(posedge systclk); #1;

    run_op(64'd3, 64'd5, 7'd0, 7'd0, 1'b0, 1'b0, 0, 0);
    run_op(64'h18, 64'h28, 7'd4, 7'd4, 1'b1, 1'b0, 0, 0);
    run_op('1, '1, 7'd127, 7'd127, 1'b1, 1'b1, 0, 0);
    run_op(64'd0, 64'h1234, 7'd3, 7'd9, 1'b1, 1'b0, 0, 0);
    run_op(64'hABCD, 64'd1, 7'd0, 7'd0, 1'b0, 1'b1, 0, 0);
    run_op(64'hABCD, 64'd0, 7'd1, 7'd2, 1'b0, 1'b0, 0, 0);

`ifdef EARLY_EXIT_EN
    poke = 1;
`else
    poke = 10;
`endif
    run_op(64'd7, 64'd9, 7'd0, 7'd0, 1'b0, 1'b0, poke, 0);
    run_op(64'd11, '1, 7'd0, 7'd0, 1'b1, 1'b0, 0, 20);
    run_op(64'd6, 64'd7, 7'd2, 7'd1, 1'b1, 1'b1, 0, 0);

    for (int k = 0; k < 8; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_op(ra, rb, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
             1'($urandom), 1'($urandom), 0, 0);
    end

    // init held high: three back-to-back operations
    for (int k = 0; k < 3; k++) begin
      qa[k] = {$urandom, $urandom};
      qb[k] = {$urandom, $urandom} >> (k * 20);
      qd1[k] = 7'($urandom_range(0, 127));
      qd2[k] = 7'($urandom_range(0, 127));
      qs1[k] = 1'($urandom);
      qs2[k] = 1'($urandom);
    end
    num1 = qa[0]; num2 = qb[0]; dotplace1 = qd1[0]; dotplace2 = qd2[0];
    sign1 = qs1[0]; sign2 = qs2[0];
    init = 1'b1;
    @(posedge systclk); #1;
    n = 0; i = 0; guard = 0;
    while (i < 3 && guard < 1000) begin
      @(posedge systclk); #1;
      n++; guard++;
      if (calcover) begin
        chk("b2b_latency", 128'(n), 128'(exp_lat(qb[i])));
        chk("b2b_result", result, {64'd0, qa[i]} * {64'd0, qb[i]});
        chk("b2b_dotplace", {120'd0, dotplaceresult}, 128'({1'b0, qd1[i]} + {1'b0, qd2[i]}));
        chk("b2b_sign", {127'd0, signresult}, {127'd0, qs1[i] ^ qs2[i]});
        i++;
        if (i < 3) begin
          num1 = qa[i]; num2 = qb[i]; dotplace1 = qd1[i]; dotplace2 = qd2[i];
          sign1 = qs1[i]; sign2 = qs2[i];
        end else begin
          init = 1'b0;
        end
        n = -1;
      end
    end
    init = 1'b0;
    chk("b2b_all_done", 128'(i), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
